// File: rtl/sa_pkg.sv
// sa_pkg: shared constants, FSM states and packed tile/vector types for the systolic-array feeder.
package sa_pkg;
   localparam int SA_N       = 4;
   localparam int SA_DW      = 8;
   localparam int SA_PSO_W   = 18;
   localparam int SA_PSO_LAT = 4;
   localparam int SA_DRAIN   = (SA_N - 1) + SA_PSO_LAT + (SA_N - 1);
   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
   typedef logic signed [SA_DW-1:0] elem_t;
   typedef elem_t [SA_N-1:0] vec_t;
   typedef vec_t [SA_N-1:0] tile_t;
endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: DEPTH extra delay stages ahead of a registered output, synchronous active-low clear.
module sa_skew_line
   import sa_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic  clk,
   input  logic  rst,
   input  elem_t d,
   output elem_t q
);
   elem_t pipe [DEPTH+1];
   always_ff @(posedge clk) begin
      if (!rst) pipe <= '{default: '0};
      else begin
         pipe[0] <= d;
         for (int i = 1; i <= DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign q = pipe[DEPTH];
endmodule

// File: rtl/sa_act_feeder.sv
// sa_act_feeder: loads a weight tile then streams diagonally skewed activations into a 4x4 systolic array.
// Optional SA_ACT_FEEDER_PERF_EN adds a saturating stall_cnt of idle STREAM cycles.
module sa_act_feeder
   import sa_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  tile_t           w_tile,
   input  logic            act_valid,
   output logic            act_ready,
   input  vec_t            act_data,
   input  logic            act_last,
   output logic            L,
   output elem_t           wi0,
   output elem_t           wi1,
   output elem_t           wi2,
   output elem_t           wi3,
   output elem_t           ai0,
   output elem_t           ai1,
   output elem_t           ai2,
   output elem_t           ai3,
   output logic [SA_N-1:0] pso_valid,
   output logic            busy,
`ifdef SA_ACT_FEEDER_PERF_EN
   output logic [15:0]     stall_cnt,
`endif
   output logic            done
);
   localparam int VPW = SA_PSO_LAT + SA_N - 1;
   state_t state, nstate;
   tile_t wreg, src;
   vec_t wi, ai;
   logic [1:0] lcnt, nlcnt;
   logic [3:0] dcnt;
   logic [VPW-1:0] vp;
   logic tag, acc;
   assign acc = act_valid & act_ready;
   assign src = (state == IDLE) ? w_tile : wreg;
   assign nlcnt = (state == LOAD_W) ? lcnt + 2'd1 : 2'd0;
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else state <= nstate;
   end
   always_comb begin
      nstate = (state == IDLE   && start)                  ? LOAD_W :
               (state == LOAD_W && lcnt == 2'(SA_N - 1))   ? STREAM :
               (state == STREAM && acc && act_last)        ? DRAIN  :
               (state == DRAIN  && dcnt == 4'd0)           ? IDLE   : state;
   end
   always_comb begin
      act_ready = (state == STREAM);
      busy      = (state != IDLE);
   end
   // Outputs are registered from the next state so L/wi line up with LOAD_W exactly; bottom row goes first.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wreg <= '0;
         lcnt <= '0;
         dcnt <= '0;
         L    <= 1'b0;
         wi   <= '0;
         done <= 1'b0;
         tag  <= 1'b0;
         vp   <= '0;
      end else begin
         if (state == IDLE && start) wreg <= w_tile;
         lcnt <= nlcnt;
         dcnt <= (state == DRAIN) ? dcnt - 4'd1 : 4'(SA_DRAIN);
         L    <= (nstate == LOAD_W);
         wi   <= (nstate == LOAD_W) ? src[2'(SA_N - 1) - nlcnt] : '0;
         done <= (state == DRAIN && dcnt == 4'd0);
         tag  <= acc;
         vp   <= {vp[VPW-2:0], tag};
      end
   end
   for (genvar r = 0; r < SA_N; r++) begin : g_row
      sa_skew_line #(.DEPTH(r)) u_line (
         .clk (clk),
         .rst (rst),
         .d   (acc ? act_data[r] : elem_t'(0)),
         .q   (ai[r])
      );
   end
   assign pso_valid = vp[VPW-1 -: SA_N];
   assign {wi3, wi2, wi1, wi0} = wi;
   assign {ai3, ai2, ai1, ai0} = ai;
`ifdef SA_ACT_FEEDER_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) stall_cnt <= '0;
      else if (state == IDLE && start) stall_cnt <= '0;
      else if (state == STREAM && !act_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_sa_act_feeder.sv
// tb_sa_act_feeder: directed checks of weight load, skew, bubbles, handshake, reset and signed passthrough.
module tb_sa_act_feeder;
   logic clk = 1'b0;
   logic rst, start, act_valid, act_ready, act_last, L, busy, done;
   logic [127:0] w_tile;
   logic [31:0] act_data;
   logic signed [7:0] wi0, wi1, wi2, wi3, ai0, ai1, ai2, ai3;
   logic [3:0] pso_valid;
`ifdef SA_ACT_FEEDER_PERF_EN
   logic [15:0] stall_cnt;
`endif
   int n_cmp = 0;
   int n_err = 0;
   bit seen;

   always #5 clk = ~clk;

   sa_act_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .w_tile    (w_tile),
      .act_valid (act_valid),
      .act_ready (act_ready),
      .act_data  (act_data),
      .act_last  (act_last),
      .L         (L),
      .wi0       (wi0),
      .wi1       (wi1),
      .wi2       (wi2),
      .wi3       (wi3),
      .ai0       (ai0),
      .ai1       (ai1),
      .ai2       (ai2),
      .ai3       (ai3),
      .pso_valid (pso_valid),
      .busy      (busy),
`ifdef SA_ACT_FEEDER_PERF_EN
      .stall_cnt (stall_cnt),
`endif
      .done      (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic load_tile();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; act_valid = 1'b0; act_last = 1'b0; act_data = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) w_tile[(r*4+c)*8 +: 8] = 8'(10*r + c);
      repeat (2) tick();
      rst = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_L", L, 0);
      chk("rst_ready", act_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_pso", pso_valid, 0);
      chk("rst_ai0", ai0, 0);
      chk("rst_wi0", wi0, 0);

      // weight load with act_valid held high in IDLE/LOAD_W
      act_valid = 1'b1; act_data = 32'h55555555;
      chk("idle_ready", act_ready, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("load_L", L, 1);
         chk("load_ready", act_ready, 0);
         chk("load_ai0", ai0, 0);
         chk("load_wi0", wi0, 10*(3-k));
         chk("load_wi1", wi1, 10*(3-k)+1);
         chk("load_wi2", wi2, 10*(3-k)+2);
         chk("load_wi3", wi3, 10*(3-k)+3);
         if (k == 3) act_valid = 1'b0;
         tick();
      end
      chk("stream_L", L, 0);
      chk("stream_ready", act_ready, 1);
      chk("stream_ai0", ai0, 0);
      chk("stream_pso", pso_valid, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ign_L", L, 0);
      chk("start_ign_ready", act_ready, 1);

      // single vector skew, act_valid held high through DRAIN
      act_valid = 1'b1; act_last = 1'b1; act_data = {8'd4, 8'd3, 8'd2, 8'd1};
      tick();
      act_last = 1'b0; act_data = 32'h09090909;
      for (int i = 0; i < 12; i++) begin
         chk("skew_ai0", ai0, (i == 0) ? 1 : 0);
         chk("skew_ai1", ai1, (i == 1) ? 2 : 0);
         chk("skew_ai2", ai2, (i == 2) ? 3 : 0);
         chk("skew_ai3", ai3, (i == 3) ? 4 : 0);
         chk("skew_pso", pso_valid, (i >= 4 && i <= 7) ? (1 << (i - 4)) : 0);
         chk("skew_done", done, (i == 11) ? 1 : 0);
         chk("drain_ready", act_ready, 0);
         if (i == 11) chk("end_busy", busy, 0);
         tick();
      end
      act_valid = 1'b0; act_data = '0;

      // bubbles: A, gap, B
      load_tile();
      act_valid = 1'b1; act_data = {8'd8, 8'd7, 8'd6, 8'd5};
      tick();
      chk("bub_a_ai0", ai0, 5);
      act_valid = 1'b0;
      tick();
      chk("bub_gap_ai0", ai0, 0);
      act_valid = 1'b1; act_last = 1'b1; act_data = {8'd12, 8'd11, 8'd10, 8'd9};
      tick();
      act_valid = 1'b0; act_last = 1'b0;
      for (int i = 2; i <= 13; i++) begin
         chk("bub_ai0", ai0, (i == 2) ? 9 : 0);
         chk("bub_ai3", ai3, (i == 3) ? 8 : (i == 5) ? 12 : 0);
         chk("bub_pso0", pso_valid[0], (i == 4 || i == 6) ? 1 : 0);
         chk("bub_done", done, (i == 13) ? 1 : 0);
         tick();
      end

      // reset mid-STREAM
      load_tile();
      act_valid = 1'b1; act_data = 32'h01010101;
      tick();
      act_valid = 1'b0;
      chk("pre_rst_ai0", ai0, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ai0", ai0, 0);
      chk("mid_rst_ai1", ai1, 0);
      chk("mid_rst_ai2", ai2, 0);
      chk("mid_rst_ai3", ai3, 0);
      chk("mid_rst_pso", pso_valid, 0);
      chk("mid_rst_ready", act_ready, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_pso", pso_valid, 0);
         chk("post_rst_ai", {ai3, ai2, ai1, ai0}, 0);
      end

      // signed passthrough after 3 idle STREAM cycles
      load_tile();
      repeat (3) tick();
      act_valid = 1'b1; act_last = 1'b1; act_data = {8'h00, 8'hFF, 8'h7F, 8'h80};
      tick();
      act_valid = 1'b0; act_last = 1'b0; act_data = '0;
      chk("sgn_ai0", ai0, -128);
`ifdef SA_ACT_FEEDER_PERF_EN
      chk("stall_cnt", stall_cnt, 3);
`endif
      tick();
      chk("sgn_ai1", ai1, 127);
      chk("sgn_ai0_after", ai0, 0);
      tick();
      chk("sgn_ai2", ai2, -1);
      tick();
      chk("sgn_ai3", ai3, 0);
      chk("sgn_ai2_after", ai2, 0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = done;
      end
      chk("sgn_done_seen", seen, 1);
`ifdef SA_ACT_FEEDER_PERF_EN
      chk("stall_hold", stall_cnt, 3);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
